// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl -- game state controller for the runner game.
//
// Tracks the game through IDLE / RUN / OVER. While running it detects
// dinosaur/obstacle overlap inside the visible 640x480 area, counts frames
// into a score, and raises the obstacle scroll speed as the score grows.
//
// Ports
//   clk          in   system clock, all state changes on its rising edge
//   RESET        in   synchronous active-low reset
//   row_addr     in   [8:0] current scan row
//   col_addr     in   [9:0] current scan column
//   fresh        in   frame strobe, falling edge = end of frame
//   dino_px      in   dinosaur sprite pixel at the scan position
//   cactus_px    in   obstacle sprite pixel at the scan position
//   start        in   player button (level, rising edge used)
//   game_status  out  1 while running
//   game_over    out  1 while in OVER
//   speed        out  [3:0] obstacle scroll step per frame
//   score        out  [13:0] frames-survived score, 0..9999
// ---------------------------------------------------------------------------
module game_ctrl #(
  parameter logic [3:0] SPEED_INIT = 4'd2,
  parameter logic [3:0] SPEED_MAX  = 4'd12,
  parameter int         SCORE_DIV  = 6,
  parameter int         SPEED_STEP = 100
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        fresh,
  input  logic        dino_px,
  input  logic        cactus_px,
  input  logic        start,
  output logic        game_status,
  output logic        game_over,
  output logic [3:0]  speed,
  output logic [13:0] score
);

  localparam logic [7:0]  FRAME_LAST = 8'(SCORE_DIV - 1);
  localparam logic [7:0]  STEP_LAST  = 8'(SPEED_STEP - 1);
  localparam logic [13:0] SCORE_MAX  = 14'd9999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t      state;
  logic        fresh_q;
  logic        start_q;
  logic        hit;
  logic [7:0]  frame_cnt;
  // Counts score points since the last speed step, so that "score is a
  // multiple of SPEED_STEP" needs no divider.
  logic [7:0]  step_cnt;

  logic        fall_ev;
  logic        start_ev;
  logic        hit_now;

  // Edge events and visible-area overlap detection.
  always_comb begin
    fall_ev  = fresh_q & ~fresh;
    start_ev = start & ~start_q;
    hit_now  = dino_px & cactus_px & (row_addr < 9'd480) & (col_addr < 10'd640);
  end

  // Game FSM with registered outputs, score and speed counters.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      state       <= IDLE;
      game_status <= 1'b0;
      game_over   <= 1'b0;
      speed       <= SPEED_INIT;
      score       <= 14'd0;
      frame_cnt   <= 8'd0;
      step_cnt    <= 8'd0;
      hit         <= 1'b0;
      // Held high so a button held through reset gives no start edge.
      fresh_q     <= 1'b1;
      start_q     <= 1'b1;
    end else begin
      fresh_q <= fresh;
      start_q <= start;
      case (state)
        IDLE, OVER: begin
          // A start edge wins over a simultaneous frame edge; end of frame
          // is otherwise ignored outside RUN.
          if (start_ev) begin
            state       <= RUN;
            game_status <= 1'b1;
            game_over   <= 1'b0;
            speed       <= SPEED_INIT;
            score       <= 14'd0;
            frame_cnt   <= 8'd0;
            step_cnt    <= 8'd0;
            hit         <= 1'b0;
          end
        end
        RUN: begin
          if (fall_ev) begin
            hit <= 1'b0;
            // A hit latched earlier in the frame, or one on this very cycle,
            // ends the game with score and speed frozen.
            if (hit || hit_now) begin
              state       <= OVER;
              game_status <= 1'b0;
              game_over   <= 1'b1;
            end else if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= 8'd0;
              if (score != SCORE_MAX) begin
                score <= score + 14'd1;
                if (step_cnt == STEP_LAST) begin
                  step_cnt <= 8'd0;
                  if (speed < SPEED_MAX) begin
                    speed <= speed + 4'd1;
                  end
                end else begin
                  step_cnt <= step_cnt + 8'd1;
                end
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end else if (hit_now) begin
            hit <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          game_status <= 1'b0;
          game_over   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl -- self-checking bench for game_ctrl.
// A table of single-cycle vectors covers reset, start, hit filtering and
// OVER behaviour; hand-written sequences cover long frame runs, speed
// saturation, same-cycle hit at end of frame and reset with the button held.
// ---------------------------------------------------------------------------
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        RESET;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        fresh;
  logic        dino_px;
  logic        cactus_px;
  logic        start;
  logic        game_status;
  logic        game_over;
  logic [3:0]  speed;
  logic [13:0] score;

  int n_vec = 0;
  int n_bad = 0;

  game_ctrl dut (
    .clk         (clk),
    .RESET       (RESET),
    .row_addr    (row_addr),
    .col_addr    (col_addr),
    .fresh       (fresh),
    .dino_px     (dino_px),
    .cactus_px   (cactus_px),
    .start       (start),
    .game_status (game_status),
    .game_over   (game_over),
    .speed       (speed),
    .score       (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        fresh;
    logic        start;
    logic        px;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        e_status;
    logic        e_over;
    logic [3:0]  e_speed;
    logic [13:0] e_score;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic st, input logic ov,
                     input logic [3:0] sp, input logic [13:0] sc);
    n_vec++;
    if (game_status !== st || game_over !== ov || speed !== sp || score !== sc) begin
      n_bad++;
      $display("FAIL %s: got status=%0b over=%0b speed=%0d score=%0d, want status=%0b over=%0b speed=%0d score=%0d",
               name, game_status, game_over, speed, score, st, ov, sp, sc);
    end
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      fresh = 1'b1; tick();
      fresh = 1'b0; tick();
    end
  endtask

  task automatic setv(input int i, input logic r, input logic f, input logic s,
                      input logic p, input int row, input int col,
                      input logic est, input logic eov, input int esp, input int esc);
    vecs[i].rst_n    = r;
    vecs[i].fresh    = f;
    vecs[i].start    = s;
    vecs[i].px       = p;
    vecs[i].row      = 9'(row);
    vecs[i].col      = 10'(col);
    vecs[i].e_status = est;
    vecs[i].e_over   = eov;
    vecs[i].e_speed  = 4'(esp);
    vecs[i].e_score  = 14'(esc);
  endtask

  initial begin
    //      i  rst fr st px row  col  st ov sp sc
    setv( 0, 0, 1, 0, 0,   0,   0, 0, 0, 2, 0); // reset
    setv( 1, 1, 1, 0, 0,   0,   0, 0, 0, 2, 0); // idle
    setv( 2, 1, 1, 1, 0,   0,   0, 1, 0, 2, 0); // start edge -> RUN
    setv( 3, 1, 1, 1, 0,   0,   0, 1, 0, 2, 0);
    setv( 4, 1, 0, 1, 0,   0,   0, 1, 0, 2, 0); // clean frame end
    setv( 5, 1, 1, 1, 1, 490, 100, 1, 0, 2, 0); // overlap below visible rows
    setv( 6, 1, 0, 1, 1, 100, 650, 1, 0, 2, 0); // overlap right of visible cols, at fall
    setv( 7, 1, 1, 0, 0,   0,   0, 1, 0, 2, 0);
    setv( 8, 1, 1, 1, 0,   0,   0, 1, 0, 2, 0); // start ignored in RUN
    setv( 9, 1, 1, 1, 1, 400, 100, 1, 0, 2, 0); // visible hit, still running
    setv(10, 1, 1, 1, 0,   0,   0, 1, 0, 2, 0);
    setv(11, 1, 0, 1, 0,   0,   0, 0, 1, 2, 0); // frame end with hit -> OVER
    setv(12, 1, 1, 0, 0,   0,   0, 0, 1, 2, 0);
    setv(13, 1, 0, 0, 0,   0,   0, 0, 1, 2, 0); // fall ignored in OVER
    setv(14, 1, 1, 1, 0,   0,   0, 1, 0, 2, 0); // restart from OVER

    RESET = 1'b0; fresh = 1'b1; start = 1'b0; dino_px = 1'b0; cactus_px = 1'b0;
    row_addr = 9'd0; col_addr = 10'd0;
    tick();

    for (int i = 0; i < NV; i++) begin
      RESET     = vecs[i].rst_n;
      fresh     = vecs[i].fresh;
      start     = vecs[i].start;
      dino_px   = vecs[i].px;
      cactus_px = vecs[i].px;
      row_addr  = vecs[i].row;
      col_addr  = vecs[i].col;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].e_status, vecs[i].e_over,
          vecs[i].e_speed, vecs[i].e_score);
    end
    dino_px = 1'b0; cactus_px = 1'b0; row_addr = 9'd0; col_addr = 10'd0;

    // Score accumulates, then a hit on the frame-end cycle ends the game.
    start = 1'b0;
    frames(12);
    chk("score_12_frames", 1'b1, 1'b0, 4'd2, 14'd2);
    fresh = 1'b1; tick();
    dino_px = 1'b1; cactus_px = 1'b1; row_addr = 9'd200; col_addr = 10'd300;
    fresh = 1'b0; tick();
    chk("hit_at_fall", 1'b0, 1'b1, 4'd2, 14'd2);
    dino_px = 1'b0; cactus_px = 1'b0;

    // Restart with a simultaneous frame edge: that edge must not count.
    fresh = 1'b1; tick();
    fresh = 1'b0; start = 1'b1; tick();
    chk("restart_over", 1'b1, 1'b0, 4'd2, 14'd0);
    frames(5);
    chk("div_5_frames", 1'b1, 1'b0, 4'd2, 14'd0);
    frames(1);
    chk("div_6_frames", 1'b1, 1'b0, 4'd2, 14'd1);
    frames(593);
    chk("score_599f", 1'b1, 1'b0, 4'd2, 14'd99);
    frames(1);
    chk("score_600f", 1'b1, 1'b0, 4'd3, 14'd100);
    frames(5400);
    chk("score_6000f", 1'b1, 1'b0, 4'd12, 14'd1000);
    frames(600);
    chk("speed_sat", 1'b1, 1'b0, 4'd12, 14'd1100);

    // Mid-frame hit: still running until the frame ends, score frozen.
    dino_px = 1'b1; cactus_px = 1'b1; row_addr = 9'd400; col_addr = 10'd100;
    fresh = 1'b1; tick();
    chk("midhit_run", 1'b1, 1'b0, 4'd12, 14'd1100);
    dino_px = 1'b0; cactus_px = 1'b0;
    tick();
    chk("midhit_hold", 1'b1, 1'b0, 4'd12, 14'd1100);
    fresh = 1'b0; tick();
    chk("midhit_over", 1'b0, 1'b1, 4'd12, 14'd1100);

    // Reset during RUN with the button held.
    start = 1'b0; fresh = 1'b1; tick();
    start = 1'b1; tick();
    chk("restart2", 1'b1, 1'b0, 4'd2, 14'd0);
    frames(342);
    chk("score_57", 1'b1, 1'b0, 4'd2, 14'd57);
    RESET = 1'b0; fresh = 1'b1;
    dino_px = 1'b1; cactus_px = 1'b1;
    tick();
    chk("reset_run", 1'b0, 1'b0, 4'd2, 14'd0);
    dino_px = 1'b0; cactus_px = 1'b0;
    RESET = 1'b1; tick();
    chk("held_start", 1'b0, 1'b0, 4'd2, 14'd0);
    frames(2);
    chk("held_frames", 1'b0, 1'b0, 4'd2, 14'd0);
    start = 1'b0; tick();
    chk("release", 1'b0, 1'b0, 4'd2, 14'd0);
    start = 1'b1; tick();
    chk("repress", 1'b1, 1'b0, 4'd2, 14'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
